uart_tx: RTL and testbench
==========================

# uart_tx

Serial transmitter that drains the read side of a `fifo` instance and shifts each word out as an asynchronous serial frame: start bit, data bits LSB first, then stop bit. It sits between a transmit `fifo` and the board TX pin. The block pops words autonomously whenever the FIFO is non-empty and the line is free, and sends back-to-back frames with no idle gap.

## Interface
- `data_width`, 8, bits per frame; must match the FIFO's `data_width`
- `clks_per_bit`, 868, `clk` cycles per serial bit (100 MHz / 115200); legal range ≥ 2
- `cnt_width`, `` `log2(clks_per_bit) ``, width of the bit-period counter (from `util.vh`)

- `clk`  in  1  system clock; all logic is on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_dout`  in  data_width  FIFO head word; valid whenever `fifo_empty` = 0
- `fifo_rd_en`  out  1  pop strobe; the FIFO advances on the same rising edge
- `serial_out`  out  1  TX line; idles high
- `busy`  out  1  high while a frame is in flight (any state other than IDLE)

## Operation
- FIFO contract (show-ahead):
  - `fifo_dout` holds the head word combinationally while `fifo_empty` = 0.
  - A cycle with `fifo_rd_en` = 1 both captures `fifo_dout` into the shift register and pops the FIFO.
- States: IDLE, START, DATA, STOP. State is encoded in 2 bits, plus:
  - `bit_cnt`, `cnt_width` bits, counting 0..`clks_per_bit`-1
  - `bit_idx`, `` `log2(data_width) ``+1 bits
  - `shreg`, `data_width` bits
- `fifo_rd_en` is combinational: `!rst && !fifo_empty && (state==IDLE || (state==STOP && bit_cnt==clks_per_bit-1))`.
- IDLE:
  - `serial_out` = 1.
  - On `fifo_rd_en`: load `shreg` ← `fifo_dout`, clear `bit_cnt`, go to START.
- START:
  - `serial_out` = 0 for `clks_per_bit` cycles.
  - At `bit_cnt`==`clks_per_bit`-1: clear counters, go to DATA.
- DATA:
  - `serial_out` = `shreg[0]`.
  - At the end of each bit period: shift `shreg` right by 1 and increment `bit_idx`.
  - After bit `data_width`-1: go to STOP.
- STOP:
  - `serial_out` = 1 for `clks_per_bit` cycles.
  - On the last cycle, if `fifo_rd_en`: load the next word and go directly to START. Otherwise go to IDLE.
- `serial_out` is driven from a register, so there are no glitches and it is stable for a whole bit period.
- `fifo_empty` is ignored outside the pop-decision cycles. A FIFO that fills mid-frame has no effect until the end of the stop bit.

## Timing
- Reset values (register outputs take effect on the first edge with `rst`=1):
  - `serial_out`=1, `busy`=0, state=IDLE, counters=0.
  - `fifo_rd_en`=0 throughout reset.
- Latency: pop in cycle N → `serial_out` falls in cycle N+1 (first start-bit cycle).
- Frame length: exactly (`data_width`+2)·`clks_per_bit` cycles of line time.
- Back-to-back frames: the next start bit immediately follows the last stop-bit cycle (zero idle cycles).
- Exactly one pop per frame. No pop is issued while `fifo_empty`=1 or during reset.
- `busy`:
  - Rises the cycle after the pop.
  - Falls the cycle after the last stop-bit cycle only if no chained pop occurred.
- Reset mid-frame:
  - Next cycle `serial_out`=1 and state=IDLE.
  - The word in flight is discarded and is not re-read.
- Counter widths: `bit_cnt` compares against `clks_per_bit`-1 and never wraps past it. `bit_idx` reaches `data_width` without overflow.

## Test plan
- `clks_per_bit`=4, FIFO holds 0xA5:
  - → one pop.
  - `serial_out` reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; 40 cycles total.
  - `busy` high for 40 cycles, then 0.
- FIFO holds 0x00, 0xFF, 0x3C:
  - → three pops, each exactly 40 cycles apart.
  - No high idle gap between frames; the line decodes to 0x00, 0xFF, 0x3C.
- FIFO empty for 100 cycles → `fifo_rd_en`=0, `serial_out`=1, `busy`=0 throughout.
- `rst` pulsed during bit 3 of 0x5A:
  - → `serial_out`=1 and `busy`=0 on the next cycle; no pop during reset.
  - With a word 0x81 waiting, it is popped on the first cycle after reset and sent intact.
- Word written into an empty FIFO mid-stop-bit of the previous frame → pop occurs on the last stop cycle and the next start bit follows with no gap.
- `clks_per_bit`=2, `data_width`=8, byte 0x01 → frame of 20 cycles, with the LSB high for cycles 3–4 after the first start-bit cycle.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - transmitter that drains a show-ahead FIFO into start / LSB-first data / stop frames
module uart_tx #(
  parameter int data_width   = 8,
  parameter int clks_per_bit = 868,
  parameter int cnt_width    = $clog2(clks_per_bit)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [data_width-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  serial_out,
  output logic                  busy
);

  localparam int idx_width = $clog2(data_width) + 1;
  localparam logic [cnt_width-1:0] cnt_last = cnt_width'(clks_per_bit - 1);
  localparam logic [cnt_width-1:0] cnt_one  = cnt_width'(1);
  localparam logic [idx_width-1:0] idx_last = idx_width'(data_width - 1);
  localparam logic [idx_width-1:0] idx_one  = idx_width'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_n;
  logic [cnt_width-1:0]  bit_cnt, bit_cnt_n;
  logic [idx_width-1:0]  bit_idx, bit_idx_n;
  logic [data_width-1:0] shreg, shreg_n;
  logic                  serial_n;
  logic                  bit_end;

  assign bit_end    = (bit_cnt == cnt_last);
  // Pops happen only when the line is free or on the final stop-bit cycle, so frames chain with no gap.
  assign fifo_rd_en = !rst && !fifo_empty && (state == IDLE || (state == STOP && bit_end));
  assign busy       = (state != IDLE);

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    serial_n  = 1'b1;
    case (state)
      IDLE: begin
        if (fifo_rd_en) begin
          shreg_n   = fifo_dout;
          bit_cnt_n = '0;
          state_n   = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          bit_cnt_n = bit_cnt + cnt_one;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          shreg_n   = shreg >> 1;
          bit_idx_n = bit_idx + idx_one;
          if (bit_idx == idx_last) begin
            state_n = STOP;
          end
        end else begin
          bit_cnt_n = bit_cnt + cnt_one;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_n = '0;
          if (fifo_rd_en) begin
            shreg_n = fifo_dout;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt + cnt_one;
        end
      end
      default: state_n = IDLE;
    endcase

    // The line level is computed from the next state so the registered output lines up with it.
    case (state_n)
      START:   serial_n = 1'b0;
      DATA:    serial_n = shreg_n[0];
      default: serial_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      serial_out <= serial_n;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with a FIFO model and a line decoder
module tb_uart_tx;

  localparam int cpb       = 4;
  localparam int frame_len = 10 * cpb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       fifo_empty, fifo_rd_en, serial_out, busy;
  logic [7:0] fifo_dout;
  logic       empty2, rd_en2, serial2, busy2;
  logic [7:0] dout2;

  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         cyc = 0;
  int         pops2 = 0;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] sb [$];
  int         pop_times [$];
  int         frame_starts [$];

  bit                   mon_active = 1'b0;
  int                   mon_cyc = 0;
  logic [frame_len-1:0] mon_line;
  logic [7:0]           mon_exp;
  bit                   mon_has_exp;
  logic [7:0]           mon_got;
  bit                   mon_ok;
  int                   frames_done = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = mem[rd_ptr[5:0]];

  uart_tx #(.data_width(8), .clks_per_bit(cpb)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .serial_out(serial_out), .busy(busy)
  );

  uart_tx #(.data_width(8), .clks_per_bit(2)) dut2 (
    .clk(clk), .rst(rst), .fifo_empty(empty2), .fifo_dout(dout2),
    .fifo_rd_en(rd_en2), .serial_out(serial2), .busy(busy2)
  );

  // FIFO model: pops land on the same rising edge as the strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    checks++;
    if (fifo_rd_en && (fifo_empty || rst)) begin
      errors++;
      $display("FAIL illegal_pop: rd_en=%b empty=%b rst=%b at cycle %0d, required no pop", fifo_rd_en, fifo_empty, rst, cyc);
    end
    if (fifo_rd_en) begin
      rd_ptr <= rd_ptr + 1;
      pop_times.push_back(cyc);
    end
    if (rd_en2) pops2++;
  end

  // Line decoder: collects one frame of samples, aborts if busy drops early (reset).
  always @(negedge clk) begin
    if (mon_active) begin
      if (busy !== 1'b1) begin
        mon_active = 1'b0;
      end else begin
        mon_line[mon_cyc] = serial_out;
        mon_cyc++;
        if (mon_cyc == frame_len) begin
          mon_active = 1'b0;
          mon_ok = 1'b1;
          for (int k = 0; k < 10; k++)
            for (int j = 1; j < cpb; j++)
              if (mon_line[k*cpb+j] !== mon_line[k*cpb]) mon_ok = 1'b0;
          if (mon_line[0] !== 1'b0 || mon_line[9*cpb] !== 1'b1) mon_ok = 1'b0;
          for (int i = 0; i < 8; i++) mon_got[i] = mon_line[(i+1)*cpb];
          checks++;
          if (!mon_ok || !mon_has_exp || mon_got !== mon_exp) begin
            errors++;
            $display("FAIL frame_decode: got %h framing_ok=%0d, required %h (expected_present=%0d)", mon_got, mon_ok, mon_exp, mon_has_exp);
          end
          frames_done++;
        end
      end
    end else if (serial_out === 1'b0 && busy === 1'b1) begin
      mon_active = 1'b1;
      mon_line[0] = serial_out;
      mon_cyc = 1;
      frame_starts.push_back(cyc);
      mon_has_exp = (sb.size() != 0);
      mon_exp = mon_has_exp ? sb.pop_front() : 8'h00;
    end
  end

  task automatic fifo_write(input logic [7:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
    sb.push_back(w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    fifo_write(8'hA5);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (serial_out !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || serial2 !== 1'b1 || busy2 !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: serial=%b busy=%b rd_en=%b serial2=%b busy2=%b, required 1 0 0 1 0", serial_out, busy, fifo_rd_en, serial2, busy2);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] w;
    logic       expb;
    int         n0, k, bad;
    w = 8'hA5;
    bad = 0;
    n0 = pop_times.size();
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL single_pop_strobe: rd_en=%b, required 1", fifo_rd_en);
    end
    for (int c = 0; c < frame_len; c++) begin
      @(negedge clk);
      k = c / cpb;
      expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : w[k-1];
      if (serial_out !== expb || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_waveform: %0d cycles wrong, required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || serial_out !== 1'b1) begin
      errors++;
      $display("FAIL single_end: busy=%b serial=%b, required 0 1", busy, serial_out);
    end
    checks++;
    if (pop_times.size() - n0 != 1) begin
      errors++;
      $display("FAIL single_pop_count: %0d pops, required 1", pop_times.size() - n0);
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== 1'b0 || serial_out !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_line: rd_en=%b serial=%b busy=%b, required 0 1 0", fifo_rd_en, serial_out, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int p0, s0, f0;
    p0 = pop_times.size();
    s0 = frame_starts.size();
    f0 = frames_done;
    fifo_write(8'h00);
    fifo_write(8'hFF);
    fifo_write(8'h3C);
    for (int i = 0; i < 300 && frames_done < f0 + 3; i++) @(negedge clk);
    checks++;
    if (frames_done < f0 + 3) begin
      errors++;
      $display("FAIL b2b_timeout: %0d frames, required 3", frames_done - f0);
      return;
    end
    checks++;
    if (pop_times.size() - p0 != 3 || frame_starts.size() - s0 != 3) begin
      errors++;
      $display("FAIL b2b_counts: pops=%0d frames=%0d, required 3 3", pop_times.size() - p0, frame_starts.size() - s0);
      return;
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (pop_times[p0+i] - pop_times[p0+i-1] != frame_len || frame_starts[s0+i] - frame_starts[s0+i-1] != frame_len) begin
        errors++;
        $display("FAIL b2b_spacing: pop gap %0d start gap %0d, required %0d", pop_times[p0+i] - pop_times[p0+i-1], frame_starts[s0+i] - frame_starts[s0+i-1], frame_len);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_stop_write();
    int p0, s0, f0, s;
    p0 = pop_times.size();
    s0 = frame_starts.size();
    f0 = frames_done;
    fifo_write(8'h11);
    for (int i = 0; i < 100 && frame_starts.size() == s0; i++) @(negedge clk);
    checks++;
    if (frame_starts.size() == s0) begin
      errors++;
      $display("FAIL mid_stop_start_timeout: no frame, required one");
      return;
    end
    s = frame_starts[s0];
    while (cyc < s + 37) @(negedge clk);
    fifo_write(8'h22);
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0 || serial_out !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_stop_early: rd_en=%b serial=%b busy=%b, required 0 1 1", fifo_rd_en, serial_out, busy);
    end
    for (int i = 0; i < 200 && frames_done < f0 + 2; i++) @(negedge clk);
    checks++;
    if (frames_done < f0 + 2 || pop_times.size() - p0 != 2) begin
      errors++;
      $display("FAIL mid_stop_frames: frames=%0d pops=%0d, required 2 2", frames_done - f0, pop_times.size() - p0);
      return;
    end
    checks++;
    if (pop_times[p0+1] != s + frame_len - 1 || frame_starts[s0+1] - frame_starts[s0] != frame_len) begin
      errors++;
      $display("FAIL mid_stop_chain: pop at %0d start gap %0d, required %0d %0d", pop_times[p0+1], frame_starts[s0+1] - frame_starts[s0], s + frame_len - 1, frame_len);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int p0, s0, f0, s;
    p0 = pop_times.size();
    s0 = frame_starts.size();
    f0 = frames_done;
    fifo_write(8'h5A);
    for (int i = 0; i < 100 && frame_starts.size() == s0; i++) @(negedge clk);
    checks++;
    if (frame_starts.size() == s0) begin
      errors++;
      $display("FAIL rst_mid_start_timeout: no frame, required one");
      return;
    end
    s = frame_starts[s0];
    while (cyc < s + 17) @(negedge clk);
    fifo_write(8'h81);
    rst = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_pop: rd_en=%b, required 0", fifo_rd_en);
    end
    @(negedge clk);
    checks++;
    if (serial_out !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: serial=%b busy=%b rd_en=%b, required 1 0 0", serial_out, busy, fifo_rd_en);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1 || fifo_dout !== 8'h81) begin
      errors++;
      $display("FAIL rst_mid_repop: rd_en=%b head=%h, required 1 81", fifo_rd_en, fifo_dout);
    end
    for (int i = 0; i < 200 && frames_done < f0 + 1; i++) @(negedge clk);
    checks++;
    if (frames_done != f0 + 1 || pop_times.size() - p0 != 2) begin
      errors++;
      $display("FAIL rst_mid_frames: frames=%0d pops=%0d, required 1 2", frames_done - f0, pop_times.size() - p0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cpb2();
    logic expb;
    int   bad;
    bad = 0;
    @(negedge clk);
    dout2 = 8'h01;
    empty2 = 1'b0;
    #1;
    checks++;
    if (rd_en2 !== 1'b1) begin
      errors++;
      $display("FAIL cpb2_pop: rd_en=%b, required 1", rd_en2);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) empty2 = 1'b1;
      expb = (c < 2) ? 1'b0 : (c < 4) ? 1'b1 : (c < 18) ? 1'b0 : 1'b1;
      if (serial2 !== expb || busy2 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL cpb2_waveform: %0d cycles wrong, required 0", bad);
    end
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b0 || serial2 !== 1'b1 || pops2 != 1) begin
      errors++;
      $display("FAIL cpb2_end: busy=%b serial=%b pops=%0d, required 0 1 1", busy2, serial2, pops2);
    end
  endtask

  initial begin
    dout2  = 8'h00;
    empty2 = 1'b1;
    test_reset();
    test_single_frame();
    test_idle();
    test_back_to_back();
    test_mid_stop_write();
    test_reset_mid_frame();
    test_cpb2();
    checks++;
    if (wr_ptr != rd_ptr || sb.size() != 0) begin
      errors++;
      $display("FAIL drain: written=%0d popped=%0d pending=%0d, required equal and 0", wr_ptr, rd_ptr, sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
